// File: rtl/axil_master_pkg.sv
// Shared AXI-Lite master definitions: write-side FSM states and BRESP codes.
// The read-side counterpart imports the same package.
package axil_master_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    RESP  = 2'd2
  } axil_wr_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/axis_to_axil_writer_if.sv
// Bus interfaces used by the stream-to-AXI-Lite writer: an AXI-Stream channel
// and a full AXI-Lite bus (write and read channels).
interface axi_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int DEST_WIDTH = 32,
  parameter int USER_WIDTH = 1
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [DEST_WIDTH-1:0] dest;
  logic [USER_WIDTH-1:0] user;
  logic                  last;

  modport master (output valid, data, dest, user, last, input ready);
  modport slave  (input valid, data, dest, user, last, output ready);
endinterface

interface axi_lite #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;
  logic                    arvalid;
  logic                    arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axis_to_axil_writer.sv
// Turns each accepted stream beat into one AXI-Lite single-beat write
// (address = BASE_ADDRESS + dest), flagging error responses and timeouts.
module axis_to_axil_writer
  import axil_master_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DEST_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS = '0,
  parameter int                    TIMEOUT      = 255
) (
  input  logic     clock,
  input  logic     reset,
  axi_stream.slave axis,
  axi_lite.master  axi,
  output logic     busy,
  output logic     resp_error,
  output logic     timeout
);

  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  axil_wr_state_t        state_q, state_d;
  logic                  ready_q, ready_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  busy_q, busy_d;
  logic                  resp_error_q, resp_error_d;
  logic                  timeout_q, timeout_d;
  logic                  abort;

  logic [DEST_WIDTH-1:0] dest_in;
  logic                  unused_inputs;

  assign dest_in       = axis.dest;
  assign unused_inputs = ^{axis.user, axis.last, dest_in,
                           axi.arready, axi.rvalid, axi.rdata, axi.rresp};

  always_comb begin
    state_d      = state_q;
    ready_d      = ready_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    awaddr_d     = awaddr_q;
    wdata_d      = wdata_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    count_d      = count_q;
    busy_d       = busy_q;
    resp_error_d = 1'b0;
    timeout_d    = 1'b0;
    abort        = 1'b0;

    case (state_q)
      IDLE: begin
        if (axis.valid && ready_q) begin
          awaddr_d  = BASE_ADDRESS + dest_in[ADDR_WIDTH-1:0];
          wdata_d   = axis.data;
          count_d   = '0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          ready_d   = 1'b0;
          busy_d    = 1'b1;
          state_d   = WRITE;
        end
      end

      WRITE: begin
        // AW and W complete independently; each VALID drops right after its own handshake.
        count_d   = count_q + CNT_W'(1);
        aw_done_d = aw_done_q | (awvalid_q & axi.awready);
        w_done_d  = w_done_q | (wvalid_q & axi.wready);
        awvalid_d = ~aw_done_d;
        wvalid_d  = ~w_done_d;
        if (count_q == CNT_LAST) begin
          abort = 1'b1;
        end else if (aw_done_d && w_done_d) begin
          bready_d = 1'b1;
          state_d  = RESP;
        end
      end

      RESP: begin
        // A response arriving on the last counted cycle still completes normally.
        count_d = count_q + CNT_W'(1);
        if (bready_q && axi.bvalid) begin
          resp_error_d = (axi.bresp != AXI_RESP_OKAY);
          bready_d     = 1'b0;
          ready_d      = 1'b1;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end else if (count_q == CNT_LAST) begin
          abort = 1'b1;
        end
      end

      default: begin
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        ready_d   = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
    endcase

    if (abort) begin
      timeout_d = 1'b1;
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      bready_d  = 1'b0;
      ready_d   = 1'b1;
      busy_d    = 1'b0;
      state_d   = IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      ready_q      <= 1'b1;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      count_q      <= '0;
      busy_q       <= 1'b0;
      resp_error_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      awaddr_q     <= awaddr_d;
      wdata_q      <= wdata_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      count_q      <= count_d;
      busy_q       <= busy_d;
      resp_error_q <= resp_error_d;
      timeout_q    <= timeout_d;
    end
  end

  assign axis.ready  = ready_q;
  assign axi.awvalid = awvalid_q;
  assign axi.awaddr  = awaddr_q;
  assign axi.awprot  = 3'b000;
  assign axi.wvalid  = wvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = '1;
  assign axi.bready  = bready_q;
  assign axi.arvalid = 1'b0;
  assign axi.araddr  = '0;
  assign axi.arprot  = 3'b000;
  assign axi.rready  = 1'b0;

  assign busy       = busy_q;
  assign resp_error = resp_error_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_axis_to_axil_writer.sv
// Bench for axis_to_axil_writer: configurable AXI-Lite slave, bus monitor and
// a queue-based model of the expected write sequence.
module tb_axis_to_axil_writer;

  localparam logic [31:0] BASE_ADDR = 32'h43C0_0000;
  localparam int          TO        = 16;

  logic clock;
  logic reset;
  logic busy;
  logic resp_error;
  logic timeout;

  axi_stream #(.DATA_WIDTH(32), .DEST_WIDTH(32)) axis_if ();
  axi_lite   #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) axi_if ();

  axis_to_axil_writer #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (32),
    .DEST_WIDTH  (32),
    .BASE_ADDRESS(BASE_ADDR),
    .TIMEOUT     (TO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .axis      (axis_if),
    .axi       (axi_if),
    .busy      (busy),
    .resp_error(resp_error),
    .timeout   (timeout)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // slave behaviour knobs
  int         aw_delay  = 0;
  int         w_delay   = 0;
  int         b_delay   = 0;
  bit         aw_never  = 0;
  logic [1:0] bresp_cfg = 2'b00;
  int         aw_cnt    = 0;
  int         w_cnt     = 0;
  int         b_cnt     = 0;

  // monitor state and reference model
  int          cyc        = 0;
  int          err_pulses = 0;
  int          to_pulses  = 0;
  int          ready_viol = 0;
  logic [31:0] aw_log[$];
  logic [35:0] w_log[$];
  int          accept_cyc[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  // Slave: READY after a per-channel wait measured from VALID; BVALID waits on BREADY.
  initial begin
    axi_if.awready = 1'b0;
    axi_if.wready  = 1'b0;
    axi_if.bvalid  = 1'b0;
    axi_if.bresp   = 2'b00;
    axi_if.arready = 1'b0;
    axi_if.rvalid  = 1'b0;
    axi_if.rdata   = '0;
    axi_if.rresp   = 2'b00;
    forever begin
      @(posedge clock);
      #1;
      if (axi_if.awvalid === 1'b1) begin
        axi_if.awready = !aw_never && (aw_cnt >= aw_delay);
        aw_cnt++;
      end else begin
        axi_if.awready = 1'b0;
        aw_cnt = 0;
      end
      if (axi_if.wvalid === 1'b1) begin
        axi_if.wready = (w_cnt >= w_delay);
        w_cnt++;
      end else begin
        axi_if.wready = 1'b0;
        w_cnt = 0;
      end
      if (axi_if.bready === 1'b1) begin
        axi_if.bvalid = (b_cnt >= b_delay);
        axi_if.bresp  = axi_if.bvalid ? bresp_cfg : 2'b00;
        b_cnt++;
      end else begin
        axi_if.bvalid = 1'b0;
        axi_if.bresp  = 2'b00;
        b_cnt = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (reset === 1'b0) begin
        if (axi_if.awvalid && axi_if.awready) aw_log.push_back(axi_if.awaddr);
        if (axi_if.wvalid && axi_if.wready) w_log.push_back({axi_if.wstrb, axi_if.wdata});
        if (axis_if.valid && axis_if.ready) accept_cyc.push_back(cyc);
        if (resp_error === 1'b1) err_pulses++;
        if (timeout === 1'b1) to_pulses++;
        if (axis_if.ready && (busy || axi_if.awvalid || axi_if.wvalid || axi_if.bready)) ready_viol++;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t (required finish earlier)", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clear_model();
    exp_addr.delete();
    exp_data.delete();
    aw_log.delete();
    w_log.delete();
    accept_cyc.delete();
  endtask

  // Called in the drive phase; returns in the drive phase of the cycle after acceptance.
  task automatic send_beat(input logic [31:0] dest, input logic [31:0] data);
    bit accepted;
    accepted      = 1'b0;
    axis_if.valid = 1'b1;
    axis_if.dest  = dest;
    axis_if.data  = data;
    axis_if.user  = 1'($urandom);
    axis_if.last  = 1'($urandom);
    exp_addr.push_back(BASE_ADDR + dest);
    exp_data.push_back(data);
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      if (axis_if.ready === 1'b1) begin
        accepted = 1'b1;
        break;
      end
      @(posedge clock);
      #1;
    end
    if (accepted) begin
      @(posedge clock);
      #1;
    end
    tests_run++;
    if (!accepted) begin
      tests_failed++;
      $display("[TB] FAIL beat_accept: dest %h got no ready, required accept within 64 cycles", dest);
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (axis_if.ready === 1'b1 && busy === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    @(posedge clock);
    #1;
    tests_run++;
    if (!done) begin
      tests_failed++;
      $display("[TB] FAIL idle_wait: busy=%b ready=%b, required idle within 100 cycles", busy, axis_if.ready);
    end
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    axis_if.valid = 1'b0;
    axis_if.data  = '0;
    axis_if.dest  = '0;
    axis_if.user  = '0;
    axis_if.last  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    @(negedge clock);
    tests_run++;
    if ({axis_if.ready, axi_if.awvalid, axi_if.wvalid, axi_if.bready, busy, resp_error, timeout} !== 7'b1000000) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl: got %b, required 1000000",
               {axis_if.ready, axi_if.awvalid, axi_if.wvalid, axi_if.bready, busy, resp_error, timeout});
    end
    tests_run++;
    if ({axi_if.awaddr, axi_if.wdata} !== 64'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_data: got awaddr=%h wdata=%h, required 0/0", axi_if.awaddr, axi_if.wdata);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    tests_run++;
    if ({axi_if.awprot, axi_if.wstrb, axi_if.arvalid, axi_if.araddr, axi_if.arprot, axi_if.rready}
        !== {3'b000, 4'hF, 1'b0, 32'h0, 3'b000, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL fixed_outputs: awprot=%b wstrb=%h arvalid=%b araddr=%h arprot=%b rready=%b, required 0/F/0/0/0/0",
               axi_if.awprot, axi_if.wstrb, axi_if.arvalid, axi_if.araddr, axi_if.arprot, axi_if.rready);
    end
    tests_run++;
    if ({axis_if.ready, busy} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL idle_after_reset: ready/busy got %b, required 10", {axis_if.ready, busy});
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_single_write();
    logic [4:0] obs;
    logic [4:0] expv;
    aw_delay = 0; w_delay = 0; b_delay = 0; bresp_cfg = 2'b00;
    clear_model();
    send_beat(32'h10, 32'hDEAD_BEEF);
    axis_if.valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      obs = {axis_if.ready, axi_if.awvalid, axi_if.wvalid, axi_if.bready, busy};
      case (c)
        1:       expv = 5'b01101;
        2:       expv = 5'b00011;
        default: expv = 5'b10000;
      endcase
      tests_run++;
      if (obs !== expv) begin
        tests_failed++;
        $display("[TB] FAIL single_cycle%0d: rdy/awv/wv/brdy/busy got %b, required %b", c, obs, expv);
      end
      if (c == 1) begin
        tests_run++;
        if ({axi_if.awaddr, axi_if.wdata, axi_if.wstrb} !== {32'h43C0_0010, 32'hDEAD_BEEF, 4'hF}) begin
          tests_failed++;
          $display("[TB] FAIL single_payload: got %h %h %h, required 43c00010 deadbeef f",
                   axi_if.awaddr, axi_if.wdata, axi_if.wstrb);
        end
      end
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_skewed();
    int a;
    int w;
    int last_c;
    logic [4:0] obs;
    logic [4:0] expv;
    for (int it = 0; it < 5; it++) begin
      a = (it == 0) ? 0 : $urandom_range(0, 5);
      w = (it == 0) ? 4 : $urandom_range(0, 5);
      aw_delay = a; w_delay = w; b_delay = 0; bresp_cfg = 2'b00;
      last_c = 2 + ((a > w) ? a : w);
      send_beat($urandom, $urandom);
      axis_if.valid = 1'b0;
      for (int c = 1; c <= last_c + 1; c++) begin
        @(negedge clock);
        obs  = {axis_if.ready, axi_if.awvalid, axi_if.wvalid, axi_if.bready, busy};
        expv = {(c == last_c + 1), (c <= 1 + a), (c <= 1 + w), (c == last_c), (c <= last_c)};
        tests_run++;
        if (obs !== expv) begin
          tests_failed++;
          $display("[TB] FAIL skew_a%0d_w%0d_cycle%0d: rdy/awv/wv/brdy/busy got %b, required %b",
                   a, w, c, obs, expv);
        end
        @(posedge clock);
        #1;
      end
    end
  endtask

  task automatic test_back_to_back();
    int v0;
    aw_delay = 0; w_delay = 0; b_delay = 0; bresp_cfg = 2'b00;
    clear_model();
    v0 = ready_viol;
    for (int i = 0; i < 4; i++) send_beat($urandom, $urandom);
    axis_if.valid = 1'b0;
    wait_idle();
    tests_run++;
    if (aw_log.size() !== 4 || w_log.size() !== 4) begin
      tests_failed++;
      $display("[TB] FAIL b2b_count: got %0d AW / %0d W writes, required 4", aw_log.size(), w_log.size());
    end
    for (int i = 0; i < exp_addr.size(); i++) begin
      tests_run++;
      if (i >= aw_log.size() || i >= w_log.size() ||
          aw_log[i] !== exp_addr[i] || w_log[i] !== {4'hF, exp_data[i]}) begin
        tests_failed++;
        $display("[TB] FAIL b2b_write%0d: got missing or %h/%h, required %h/%h",
                 i, (i < aw_log.size()) ? aw_log[i] : 32'h0, (i < w_log.size()) ? w_log[i] : 36'h0,
                 exp_addr[i], {4'hF, exp_data[i]});
      end
    end
    for (int i = 1; i < accept_cyc.size(); i++) begin
      tests_run++;
      if (accept_cyc[i] - accept_cyc[i-1] !== 3) begin
        tests_failed++;
        $display("[TB] FAIL b2b_rate%0d: beat spacing got %0d cycles, required 3",
                 i, accept_cyc[i] - accept_cyc[i-1]);
      end
    end
    tests_run++;
    if (ready_viol - v0 !== 0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_ready_busy: ready high while busy %0d times, required 0", ready_viol - v0);
    end
  endtask

  task automatic test_error_response();
    int e0;
    logic [1:0] obs;
    logic [1:0] expv;
    aw_delay = 0; w_delay = 0; b_delay = 0; bresp_cfg = 2'b10;
    clear_model();
    e0 = err_pulses;
    send_beat($urandom, $urandom);
    axis_if.valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      obs  = {resp_error, axis_if.ready};
      expv = (c == 3) ? 2'b11 : (c == 4) ? 2'b01 : 2'b00;
      tests_run++;
      if (obs !== expv) begin
        tests_failed++;
        $display("[TB] FAIL slverr_cycle%0d: resp_error/ready got %b, required %b", c, obs, expv);
      end
      @(posedge clock);
      #1;
    end
    tests_run++;
    if (err_pulses - e0 !== 1) begin
      tests_failed++;
      $display("[TB] FAIL slverr_pulse_len: got %0d error cycles, required 1", err_pulses - e0);
    end
    bresp_cfg = 2'b00;
    e0 = err_pulses;
    send_beat($urandom, $urandom);
    axis_if.valid = 1'b0;
    wait_idle();
    tests_run++;
    if (err_pulses - e0 !== 0 || aw_log.size() !== 2 || aw_log[aw_log.size()-1] !== exp_addr[1]) begin
      tests_failed++;
      $display("[TB] FAIL after_error: errors %0d, writes %0d, last addr %h, required 0, 2, %h",
               err_pulses - e0, aw_log.size(), aw_log[aw_log.size()-1], exp_addr[1]);
    end
  endtask

  task automatic test_timeout();
    int t0;
    int e0;
    logic [2:0] obs3;
    logic [2:0] exp3;
    logic [3:0] obs4;
    logic [3:0] exp4;
    // AW never accepted
    aw_delay = 0; w_delay = 0; b_delay = 0; aw_never = 1'b1; bresp_cfg = 2'b00;
    t0 = to_pulses;
    send_beat($urandom, $urandom);
    axis_if.valid = 1'b0;
    for (int c = 1; c <= TO + 2; c++) begin
      @(negedge clock);
      obs3 = {timeout, axi_if.awvalid, axis_if.ready};
      exp3 = (c <= TO) ? 3'b010 : (c == TO + 1) ? 3'b101 : 3'b001;
      tests_run++;
      if (obs3 !== exp3) begin
        tests_failed++;
        $display("[TB] FAIL to_noaw_cycle%0d: timeout/awv/ready got %b, required %b", c, obs3, exp3);
      end
      if (c == TO + 1) begin
        tests_run++;
        if ({axi_if.wvalid, axi_if.bready, busy} !== 3'b000) begin
          tests_failed++;
          $display("[TB] FAIL to_noaw_drop: wv/brdy/busy got %b, required 000",
                   {axi_if.wvalid, axi_if.bready, busy});
        end
      end
      @(posedge clock);
      #1;
    end
    aw_never = 1'b0;
    tests_run++;
    if (to_pulses - t0 !== 1) begin
      tests_failed++;
      $display("[TB] FAIL to_pulse_len: got %0d timeout cycles, required 1", to_pulses - t0);
    end
    // B arrives on the final counted cycle (wins), then one cycle too late (times out)
    for (int late = 0; late < 2; late++) begin
      b_delay   = TO - 2 + late;
      bresp_cfg = 2'b10;
      t0 = to_pulses;
      e0 = err_pulses;
      send_beat($urandom, $urandom);
      axis_if.valid = 1'b0;
      for (int c = 1; c <= TO + 2; c++) begin
        @(negedge clock);
        obs4 = {timeout, resp_error, axi_if.bready, axis_if.ready};
        if (c == 1)            exp4 = 4'b0000;
        else if (c <= TO)      exp4 = 4'b0010;
        else if (c == TO + 1)  exp4 = (late == 0) ? 4'b0101 : 4'b1001;
        else                   exp4 = 4'b0001;
        tests_run++;
        if (obs4 !== exp4) begin
          tests_failed++;
          $display("[TB] FAIL to_late%0d_cycle%0d: timeout/resp_err/brdy/ready got %b, required %b",
                   late, c, obs4, exp4);
        end
        @(posedge clock);
        #1;
      end
      tests_run++;
      if ({to_pulses - t0, err_pulses - e0} !== {late, 1 - late}) begin
        tests_failed++;
        $display("[TB] FAIL to_late%0d_counts: timeouts %0d errors %0d, required %0d %0d",
                 late, to_pulses - t0, err_pulses - e0, late, 1 - late);
      end
    end
    b_delay = 0;
    bresp_cfg = 2'b00;
  endtask

  task automatic test_reset_mid_resp();
    int e0;
    int t0;
    aw_delay = 0; w_delay = 0; b_delay = 1000; bresp_cfg = 2'b00;
    clear_model();
    e0 = err_pulses;
    t0 = to_pulses;
    send_beat($urandom, $urandom);
    axis_if.valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    tests_run++;
    if (axi_if.bready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL rst_resp_setup: bready got %b, required 1", axi_if.bready);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      tests_run++;
      if ({axis_if.ready, axi_if.awvalid, axi_if.wvalid, axi_if.bready, busy, resp_error, timeout,
           axi_if.awaddr, axi_if.wdata} !== {7'b1000000, 64'd0}) begin
        tests_failed++;
        $display("[TB] FAIL rst_resp_cycle%0d: ctrl %b addr %h data %h, required 1000000/0/0", c,
                 {axis_if.ready, axi_if.awvalid, axi_if.wvalid, axi_if.bready, busy, resp_error, timeout},
                 axi_if.awaddr, axi_if.wdata);
      end
      @(posedge clock);
      #1;
    end
    b_delay = 0;
    clear_model();
    send_beat($urandom, $urandom);
    axis_if.valid = 1'b0;
    wait_idle();
    tests_run++;
    if (aw_log.size() !== 1 || aw_log[0] !== exp_addr[0] || err_pulses - e0 !== 0 || to_pulses - t0 !== 0) begin
      tests_failed++;
      $display("[TB] FAIL rst_resp_recover: writes %0d addr %h errs %0d tos %0d, required 1 %h 0 0",
               aw_log.size(), aw_log[0], err_pulses - e0, to_pulses - t0, exp_addr[0]);
    end
  endtask

  task automatic test_random();
    int errs_exp;
    int e0;
    int t0;
    int v0;
    int gap;
    logic [31:0] d;
    clear_model();
    errs_exp = 0;
    e0 = err_pulses;
    t0 = to_pulses;
    v0 = ready_viol;
    for (int i = 0; i < 24; i++) begin
      aw_delay  = $urandom_range(0, 4);
      w_delay   = $urandom_range(0, 4);
      b_delay   = $urandom_range(0, 4);
      bresp_cfg = 2'($urandom);
      if (bresp_cfg != 2'b00) errs_exp++;
      d = (i == 0) ? 32'hBC40_0010 : $urandom;
      send_beat(d, $urandom);
      axis_if.valid = 1'b0;
      wait_idle();
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clock);
        #1;
      end
    end
    tests_run++;
    if (aw_log.size() !== 24 || w_log.size() !== 24) begin
      tests_failed++;
      $display("[TB] FAIL rand_count: got %0d AW / %0d W writes, required 24", aw_log.size(), w_log.size());
    end
    for (int i = 0; i < exp_addr.size(); i++) begin
      tests_run++;
      if (i >= aw_log.size() || i >= w_log.size() ||
          aw_log[i] !== exp_addr[i] || w_log[i] !== {4'hF, exp_data[i]}) begin
        tests_failed++;
        $display("[TB] FAIL rand_write%0d: got missing or %h/%h, required %h/%h",
                 i, (i < aw_log.size()) ? aw_log[i] : 32'h0, (i < w_log.size()) ? w_log[i] : 36'h0,
                 exp_addr[i], {4'hF, exp_data[i]});
      end
    end
    tests_run++;
    if (err_pulses - e0 !== errs_exp || to_pulses - t0 !== 0 || ready_viol - v0 !== 0) begin
      tests_failed++;
      $display("[TB] FAIL rand_status: errors %0d timeouts %0d ready_busy %0d, required %0d 0 0",
               err_pulses - e0, to_pulses - t0, ready_viol - v0, errs_exp);
    end
    bresp_cfg = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_skewed();
    test_back_to_back();
    test_error_response();
    test_timeout();
    test_reset_mid_resp();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
